// File: rtl/filter_mac_accumulator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// filter_mac_accumulator : FIR tap engine, one signed 16x16 MAC per clock
// Revision: 1.0
// ---------------------------------------------------------------------------
module filter_mac_accumulator #(
  parameter int TAPS = 16
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic signed [15:0]        sample_in,
  input  logic                      sample_valid,
  input  logic [$clog2(TAPS)-1:0]   rf_taps,
  input  logic                      delay_clear,
  input  logic signed [15:0]        coef_data,
  output logic [$clog2(TAPS)-1:0]   coef_addr,
  output logic signed [39:0]        acc_out,
  output logic                      final_state,
  output logic                      busy,
  output logic                      sample_overrun
);

  localparam int AW = $clog2(TAPS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                r_final;
  logic                r_busy;
  logic                r_overrun;
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_base;
  logic [AW-1:0]       r_n_m1;
  logic [AW-1:0]       r_k;
  logic signed [39:0]  r_acc;
  logic signed [15:0]  r_dline [TAPS];

  logic [AW-1:0]       w_rd_idx;
  logic signed [15:0]  w_tap;
  logic signed [31:0]  w_tap_ext;
  logic signed [31:0]  w_coef_ext;
  logic signed [31:0]  w_prod;
  logic signed [39:0]  w_prod_ext;

  // Newest sample sits at base; older taps wrap backwards through the ring.
  assign w_rd_idx   = r_base - r_k;
  assign w_tap      = r_dline[w_rd_idx];
  assign w_tap_ext  = {{16{w_tap[15]}}, w_tap};
  assign w_coef_ext = {{16{coef_data[15]}}, coef_data};
  assign w_prod     = w_tap_ext * w_coef_ext;
  assign w_prod_ext = {{8{w_prod[31]}}, w_prod};

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (sample_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_MAC;
        end
      end
      S_MAC: begin
        if (r_k == r_n_m1) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (delay_clear) begin
      w_state_nxt = S_IDLE;
      w_accept    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_final <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_final <= (w_state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb || delay_clear) begin
      r_wr_ptr  <= '0;
      r_base    <= '0;
      r_n_m1    <= '0;
      r_k       <= '0;
      r_acc     <= '0;
      r_overrun <= 1'b0;
      for (int i = 0; i < TAPS; i++) r_dline[i] <= '0;
    end else begin
      r_overrun <= sample_valid && (r_state != S_IDLE);
      if (w_accept) begin
        r_dline[r_wr_ptr] <= sample_in;
        r_base            <= r_wr_ptr;
        r_wr_ptr          <= r_wr_ptr + AW'(1);
        r_n_m1            <= rf_taps;
        r_acc             <= '0;
        r_k               <= '0;
      end else if (r_state == S_MAC) begin
        r_acc <= r_acc + w_prod_ext;
        r_k   <= r_k + AW'(1);
      end
    end
  end

  assign coef_addr      = (r_state == S_MAC) ? r_k : '0;
  assign acc_out        = r_acc;
  assign final_state    = r_final;
  assign busy           = r_busy;
  assign sample_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_filter_mac_accumulator.sv
`default_nettype none
`timescale 1ns/1ps
// Self-checking bench: sample history model and tap-sum reference.
module tb_filter_mac_accumulator;

  localparam int TAPS = 16;

  logic               clk = 1'b0;
  logic               rstb = 1'b0;
  logic signed [15:0] sample_in = '0;
  logic               sample_valid = 1'b0;
  logic [3:0]         rf_taps = '0;
  logic               delay_clear = 1'b0;
  logic signed [15:0] coef_data;
  logic [3:0]         coef_addr;
  logic signed [39:0] acc_out;
  logic               final_state;
  logic               busy;
  logic               sample_overrun;

  logic signed [15:0] coef_mem [TAPS];
  logic signed [15:0] hist     [TAPS];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic signed [15:0] x;
    logic [3:0]         taps;
    longint             exp_acc;
    int                 exp_lat;
  } vec_t;
  vec_t imp [5];

  always #5 clk = ~clk;
  assign coef_data = coef_mem[coef_addr];

  filter_mac_accumulator #(.TAPS(TAPS)) dut (
    .clk(clk), .rstb(rstb), .sample_in(sample_in), .sample_valid(sample_valid),
    .rf_taps(rf_taps), .delay_clear(delay_clear), .coef_data(coef_data),
    .coef_addr(coef_addr), .acc_out(acc_out), .final_state(final_state),
    .busy(busy), .sample_overrun(sample_overrun)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: hist[0] is the newest accepted sample, hist[k] is k samples older.
  function automatic void model_push(input logic signed [15:0] x);
    for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < TAPS; i++) hist[i] = '0;
  endfunction

  function automatic longint model_sum(input int n);
    longint s = 0;
    for (int k = 0; k < n; k++) s += longint'(hist[k]) * longint'(coef_mem[k]);
    return s;
  endfunction

  // Sends one sample; optionally injects a second strobe at cycle inj_at (1 = first MAC cycle).
  task automatic run_sample(input logic signed [15:0] x, input logic [3:0] taps,
                            input int inj_at, input logic signed [15:0] inj_x,
                            output longint res, output int lat);
    int     n = int'(taps) + 1;
    int     cyc = 1;
    int     ovr = 0;
    int     addr_err = 0;
    bit     seen = 1'b0;
    longint expv;
    res = 0;
    lat = 0;
    sample_in = x; rf_taps = taps; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    sample_in = 16'($urandom);
    rf_taps = 4'($urandom);
    model_push(x);
    expv = model_sum(n);
    while (!seen && cyc < 40) begin
      if (sample_overrun) ovr++;
      if (final_state) begin
        seen = 1'b1;
        lat = cyc;
        res = longint'(acc_out);
      end else begin
        if (cyc <= n && int'(coef_addr) != cyc - 1) addr_err++;
        if (cyc == inj_at) begin
          sample_valid = 1'b1;
          sample_in = inj_x;
        end
        step();
        sample_valid = 1'b0;
        cyc++;
      end
    end
    check("final_seen", longint'(seen), 1);
    if (seen) begin
      check("latency", longint'(lat), longint'(n + 1));
      check("acc_out", res, expv);
      step();
      if (sample_overrun) ovr++;
      check("busy_after_done", longint'(busy), 0);
      check("final_one_cycle", longint'(final_state), 0);
      check("acc_hold", longint'(acc_out), res);
    end
    check("coef_addr_seq", longint'(addr_err), 0);
    check("overrun_count", longint'(ovr), (inj_at > 0) ? 1 : 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    longint res;
    int     lat;
    int     fcount;

    for (int i = 0; i < TAPS; i++) coef_mem[i] = '0;
    model_clear();

    // Reset with inputs toggling
    rstb = 1'b0;
    for (int r = 0; r < 2; r++) begin
      sample_valid = 1'($urandom);
      delay_clear  = 1'($urandom);
      sample_in    = 16'($urandom);
      rf_taps      = 4'($urandom);
      step();
      check("rst_acc_out", longint'(acc_out), 0);
      check("rst_final", longint'(final_state), 0);
      check("rst_busy", longint'(busy), 0);
      check("rst_overrun", longint'(sample_overrun), 0);
      check("rst_coef_addr", longint'(coef_addr), 0);
    end
    sample_valid = 1'b0; delay_clear = 1'b0; sample_in = '0; rf_taps = '0;
    rstb = 1'b1;
    step();

    // Impulse response table
    for (int i = 0; i < TAPS; i++) coef_mem[i] = 16'(i + 1);
    imp[0] = '{16'sh0100, 4'd3, 64'h100, 5};
    imp[1] = '{16'sh0000, 4'd3, 64'h200, 5};
    imp[2] = '{16'sh0000, 4'd3, 64'h300, 5};
    imp[3] = '{16'sh0000, 4'd3, 64'h400, 5};
    imp[4] = '{16'sh0000, 4'd3, 64'h000, 5};
    for (int i = 0; i < 5; i++) begin
      run_sample(imp[i].x, imp[i].taps, 0, '0, res, lat);
      check("impulse_acc", res, imp[i].exp_acc);
      check("impulse_lat", longint'(lat), longint'(imp[i].exp_lat));
    end

    // Sign extension of the most negative product
    coef_mem[0] = 16'sh7FFF;
    run_sample(16'sh8000, 4'd0, 0, '0, res, lat);
    check("sign_acc", longint'(res[39:0]), 64'h0000_00FF_C000_8000);

    // Full-length worst case
    for (int i = 0; i < TAPS; i++) coef_mem[i] = 16'sh8000;
    for (int i = 0; i < 16; i++) run_sample(16'sh8000, 4'd15, 0, '0, res, lat);
    check("full_length_acc", longint'(res[39:0]), 64'h0000_0004_0000_0000);

    // Overrun: strobe during MAC is dropped
    for (int i = 0; i < TAPS; i++) coef_mem[i] = 16'($urandom);
    run_sample(16'($urandom), 4'd7, 3, 16'sh7777, res, lat);
    run_sample(16'($urandom), 4'd7, 0, '0, res, lat);
    run_sample(16'($urandom), 4'd7, 0, '0, res, lat);

    // Flush during MAC of a nonzero history
    for (int i = 0; i < 3; i++) run_sample(16'($urandom) | 16'sh0001, 4'd3, 0, '0, res, lat);
    sample_in = 16'sh4321; rf_taps = 4'd3; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    step();
    step();
    delay_clear = 1'b1;
    step();
    delay_clear = 1'b0;
    model_clear();
    check("flush_final", longint'(final_state), 0);
    check("flush_busy", longint'(busy), 0);
    check("flush_acc", longint'(acc_out), 0);
    fcount = 0;
    for (int c = 0; c < 6; c++) begin
      if (final_state) fcount++;
      step();
    end
    check("flush_no_final", longint'(fcount), 0);

    // Coincident strobe and flush in IDLE: sample dropped silently
    sample_in = 16'sh5A5A; sample_valid = 1'b1; delay_clear = 1'b1;
    step();
    sample_valid = 1'b0; delay_clear = 1'b0;
    check("coinc_busy", longint'(busy), 0);
    check("coinc_overrun", longint'(sample_overrun), 0);
    step();

    coef_mem[0] = 16'sh0001;
    for (int i = 1; i < TAPS; i++) coef_mem[i] = 16'($urandom);
    run_sample(16'sh8123, 4'd3, 0, '0, res, lat);
    check("flush_sext", res, longint'(16'sh8123));

    // Randomized traffic against the model
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < TAPS; i++) coef_mem[i] = 16'($urandom);
      run_sample(16'($urandom), 4'($urandom), 0, '0, res, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
